fifo_rd_stream_adapter: RTL and testbench

//   Read-side drain stage sitting directly downstream of the sync FIFO.

---
 rtl/fifo_rd_stream_adapter_if.sv | 22 ++
 rtl/fifo_rd_stream_adapter.sv | 78 +++++++
 tb/tb_fifo_rd_stream_adapter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_adapter_if.sv
// rtl/fifo_rd_stream_adapter_if.sv - FIFO read port plus outgoing valid/ready stream
interface fifo_rd_stream_adapter_if #(
  parameter int WIDTH = 16
);
  logic             fifo_empty;
  logic             fifo_underflow;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    input  fifo_empty, fifo_underflow, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_underflow, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - FIFO drain stage with skid buffer, flush and underflow flag
module fifo_rd_stream_adapter #(
  parameter int FIFO_WIDTH = 16,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        flush,
  fifo_rd_stream_adapter_if.master    bus,
  output logic [CNT_W-1:0]            word_cnt,
  output logic                        err_underflow
);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [FIFO_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         occ;
  logic                  inflight;
  logic                  pop, push, rd_en;
  logic [CW:0]           committed;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Slots already promised (held + returning) minus the one leaving this cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    push      = 1'b0;
    rd_en     = 1'b0;
    committed = '0;
    state_nxt = flush ? FLUSH : RUN;
    pop       = bus.m_valid & bus.m_ready;
    committed = {1'b0, occ} + (CW+1)'(inflight) - (CW+1)'(pop);
    rd_en     = !rst && (state == RUN) && !flush && en && !bus.fifo_empty &&
                (committed < (CW+1)'(SKID_DEPTH));
    push      = inflight && (state == RUN) && !flush && !bus.fifo_underflow;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != '0);
  assign bus.m_data     = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      occ           <= '0;
      head          <= '0;
      tail          <= '0;
      inflight      <= 1'b0;
      word_cnt      <= '0;
      err_underflow <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= rd_en;
      if (inflight && bus.fifo_underflow) err_underflow <= 1'b1;
      if (pop && (word_cnt != '1)) word_cnt <= word_cnt + CNT_W'(1);
      if (push) mem[tail] <= bus.fifo_dout;
      if (flush) begin
        occ  <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
        occ <= occ + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb/tb_fifo_rd_stream_adapter.sv - directed bench with behavioural FIFO and stream monitor
module tb_fifo_rd_stream_adapter;
  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic        uf;
  logic        m_ready;
  logic [3:0]  word_cnt;
  logic        err_underflow;

  fifo_rd_stream_adapter_if #(.WIDTH(16)) bus ();

  fifo_rd_stream_adapter #(
    .FIFO_WIDTH(16),
    .SKID_DEPTH(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .flush(flush),
    .bus(bus),
    .word_cnt(word_cnt),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sync FIFO: registered read data, one cycle after fifo_rd_en.
  logic [15:0] fmem [64];
  int          wr_p = 0;
  int          rd_p = 0;
  assign bus.fifo_empty     = (rd_p == wr_p);
  assign bus.fifo_underflow = uf;
  assign bus.m_ready        = m_ready;

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_dout <= fmem[rd_p % 64];
      rd_p          <= rd_p + 1;
    end
  end

  // Stream monitor: cycle stamps of reads and accepted words.
  int          cyc = 0;
  int          rd_total = 0;
  int          rx_n = 0;
  int          rd_cyc [256];
  logic [15:0] rx_data [256];
  int          rx_cyc [256];

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      rd_cyc[rd_total % 256] = cyc;
      rd_total = rd_total + 1;
    end
    if (bus.m_valid && bus.m_ready) begin
      rx_data[rx_n % 256] = bus.m_data;
      rx_cyc[rx_n % 256]  = cyc;
      rx_n = rx_n + 1;
    end
    cyc = cyc + 1;
  end

  int vec  = 0;
  int errs = 0;
  int rx_base;
  int rd_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[wr_p % 64] = base + 16'(i);
      wr_p = wr_p + 1;
    end
  endtask

  task automatic start_test();
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    flush = 1'b0;
    uf = 1'b0;
    tick(1);
    wr_p = rd_p;
    rst = 1'b0;
    tick(1);
    rx_base = rx_n;
    rd_base = rd_total;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    flush = 1'b0;
    uf = 1'b0;
    m_ready = 1'b0;
    tick(2);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_word_cnt", word_cnt, 4'd0);
    chk("rst_err", err_underflow, 1'b0);
    chk("rst_m_data", bus.m_data, 16'h0000);
    rst = 1'b0;
    tick(1);

    // Reset mid-stream with two words buffered
    load(8, 16'h0001);
    en = 1'b1;
    m_ready = 1'b1;
    tick(4);
    m_ready = 1'b0;
    tick(3);
    chk("pre_rst_m_valid", bus.m_valid, 1'b1);
    chk("pre_rst_cnt", word_cnt, 4'd2);
    rst = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("midrst_m_valid", bus.m_valid, 1'b0);
    chk("midrst_rd_en", bus.fifo_rd_en, 1'b0);
    chk("midrst_cnt", word_cnt, 4'd0);

    // Full-rate streaming
    start_test();
    load(8, 16'h0001);
    en = 1'b1;
    m_ready = 1'b1;
    tick(14);
    chk("stream_count", rx_n - rx_base, 8);
    chk("stream_latency", rx_cyc[rx_base % 256] - rd_cyc[rd_base % 256], 2);
    for (int i = 0; i < 8; i++) begin
      chk("stream_data", rx_data[(rx_base + i) % 256], 16'(i + 1));
      chk("stream_gapless", rx_cyc[(rx_base + i) % 256] - rx_cyc[rx_base % 256], i);
    end
    chk("stream_cnt", word_cnt, 4'd8);

    // Backpressure
    start_test();
    load(5, 16'h0001);
    en = 1'b1;
    tick(6);
    chk("bp_reads", rd_total - rd_base, 2);
    chk("bp_rd_en", bus.fifo_rd_en, 1'b0);
    chk("bp_m_valid", bus.m_valid, 1'b1);
    chk("bp_m_data", bus.m_data, 16'h0001);
    tick(3);
    chk("bp_m_data_hold", bus.m_data, 16'h0001);
    chk("bp_reads_hold", rd_total - rd_base, 2);
    m_ready = 1'b1;
    tick(10);
    chk("bp_count", rx_n - rx_base, 5);
    for (int i = 0; i < 5; i++) chk("bp_data", rx_data[(rx_base + i) % 256], 16'(i + 1));
    chk("bp_cnt", word_cnt, 4'd5);

    // Flush right after 0x0012 is accepted
    start_test();
    load(8, 16'h0010);
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rx_n - rx_base >= 3) break;
    end
    chk("fl_wait_0012", rx_n - rx_base, 3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("fl_state_m_valid", bus.m_valid, 1'b0);
    chk("fl_state_rd_en", bus.fifo_rd_en, 1'b0);
    chk("fl_pop_in_flush", rx_n - rx_base, 4);
    tick(1);
    chk("fl_resume_rd_en", bus.fifo_rd_en, 1'b1);
    chk("fl_resume_m_valid", bus.m_valid, 1'b0);
    tick(10);
    chk("fl_count", rx_n - rx_base, 7);
    chk("fl_d0", rx_data[(rx_base + 0) % 256], 16'h0010);
    chk("fl_d1", rx_data[(rx_base + 1) % 256], 16'h0011);
    chk("fl_d2", rx_data[(rx_base + 2) % 256], 16'h0012);
    chk("fl_d3", rx_data[(rx_base + 3) % 256], 16'h0013);
    chk("fl_d4", rx_data[(rx_base + 4) % 256], 16'h0015);
    chk("fl_d5", rx_data[(rx_base + 5) % 256], 16'h0016);
    chk("fl_d6", rx_data[(rx_base + 6) % 256], 16'h0017);
    chk("fl_cnt", word_cnt, 4'd7);

    // Underflow on the second word's return cycle
    start_test();
    load(4, 16'h0001);
    en = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rd_total - rd_base >= 2) break;
    end
    chk("uf_wait_reads", rd_total - rd_base, 2);
    chk("uf_err_before", err_underflow, 1'b0);
    uf = 1'b1;
    tick(1);
    uf = 1'b0;
    tick(12);
    chk("uf_count", rx_n - rx_base, 3);
    chk("uf_d0", rx_data[(rx_base + 0) % 256], 16'h0001);
    chk("uf_d1", rx_data[(rx_base + 1) % 256], 16'h0003);
    chk("uf_d2", rx_data[(rx_base + 2) % 256], 16'h0004);
    chk("uf_err", err_underflow, 1'b1);
    chk("uf_cnt", word_cnt, 4'd3);
    en = 1'b0;
    m_ready = 1'b0;
    tick(10);
    chk("uf_err_sticky", err_underflow, 1'b1);

    // Saturating word count
    start_test();
    load(20, 16'h0100);
    en = 1'b1;
    m_ready = 1'b1;
    tick(30);
    chk("sat_count", rx_n - rx_base, 20);
    for (int i = 0; i < 20; i++) chk("sat_data", rx_data[(rx_base + i) % 256], 16'h0100 + 16'(i));
    chk("sat_cnt", word_cnt, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
